// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, instruction
// classes, PC-control codes, branch condition codes and the flag selector.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_MEM   = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU_RR  = 3'b000,
    CL_ALU_IMM = 3'b001,
    CL_LOAD    = 3'b010,
    CL_STORE   = 3'b011,
    CL_BR_SET  = 3'b100,
    CL_BR_CLR  = 3'b101,
    CL_JUMP    = 3'b110,
    CL_HALT    = 3'b111
  } class_e;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  localparam logic [1:0] CND_Z = 2'b00;
  localparam logic [1:0] CND_N = 2'b01;
  localparam logic [1:0] CND_C = 2'b10;
  localparam logic [1:0] CND_V = 2'b11;

  localparam int unsigned FS_PASS_A = 0;

  // Pick the ALU flag named by a branch condition field.
  function automatic logic sel_flag(input logic [1:0] cnd,
                                    input logic v, input logic c,
                                    input logic n, input logic z);
    logic f;
    case (cnd)
      CND_Z:   f = z;
      CND_N:   f = n;
      CND_C:   f = c;
      default: f = v;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mc_insn_decode.sv
// Combinational control-word decode: (state, IR, flags, mem_ready) -> PS, IL,
// MB, FS, MD, RW, MM, MW, mem_req. Mealy on mem_ready and on the flags.
module mc_insn_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 7,
  parameter int FSW = 4
) (
  input  state_e         state_i,
  input  logic [OPW-1:0] ir_i,
  input  logic           v_i,
  input  logic           c_i,
  input  logic           n_i,
  input  logic           z_i,
  input  logic           mem_ready_i,
  output logic [1:0]     ps_o,
  output logic           il_o,
  output logic           mb_o,
  output logic [FSW-1:0] fs_o,
  output logic           md_o,
  output logic           rw_o,
  output logic           mm_o,
  output logic           mw_o,
  output logic           mem_req_o
);

  class_e cls;
  logic   flag;
  // Bits of IR between the class and function fields carry no meaning here.
  logic   ir_unused;

  assign cls       = class_e'(ir_i[OPW-1:OPW-3]);
  assign flag      = sel_flag(ir_i[1:0], v_i, c_i, n_i, z_i);
  assign ir_unused = ^ir_i;

  // Control word: everything defaults low, each state raises only its strobes.
  always_comb begin
    ps_o      = PS_HOLD;
    il_o      = 1'b0;
    mb_o      = 1'b0;
    fs_o      = FSW'(FS_PASS_A);
    md_o      = 1'b0;
    rw_o      = 1'b0;
    mm_o      = 1'b0;
    mw_o      = 1'b0;
    mem_req_o = 1'b0;
    case (state_i)
      ST_FETCH: begin
        mm_o      = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          il_o = 1'b1;
          ps_o = PS_INC;
        end
      end
      ST_EXEC: begin
        case (cls)
          CL_ALU_RR, CL_ALU_IMM: begin
            fs_o = ir_i[FSW-1:0];
            mb_o = ir_i[OPW-3];
            rw_o = 1'b1;
          end
          CL_BR_SET: ps_o = flag ? PS_BR : PS_HOLD;
          CL_BR_CLR: ps_o = flag ? PS_HOLD : PS_BR;
          CL_JUMP:   ps_o = PS_JMP;
          default:   ;
        endcase
      end
      ST_MEM: begin
        mem_req_o = 1'b1;
        if (cls == CL_STORE) begin
          mw_o = 1'b1;
        end else if (mem_ready_i) begin
          md_o = 1'b1;
          rw_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control sequencer: holds the instruction register and the
// FETCH/EXEC/MEM/HALT state, and drives the datapath control word.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FETCH | read instruction at PC; load IR and bump PC on mem_ready
//   ST_EXEC  | ALU op / branch / jump resolve here; load/store go to MEM
//   ST_MEM   | data access at register-A address, held until mem_ready
//   ST_HALT  | idle with all strobes low until reset
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPW = 7,
  parameter int FSW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] instr,
  input  logic           mem_ready,
  input  logic           V,
  input  logic           C,
  input  logic           N,
  input  logic           Z,
  output logic [1:0]     state,
  output logic [1:0]     PS,
  output logic           IL,
  output logic           MB,
  output logic [FSW-1:0] FS,
  output logic           MD,
  output logic           RW,
  output logic           MM,
  output logic           MW,
  output logic           mem_req
);

  state_e         state_q, state_d;
  logic [OPW-1:0] ir_q, ir_d;
  class_e         cls;

  logic [1:0]     dec_ps;
  logic           dec_il, dec_mb, dec_md, dec_rw, dec_mm, dec_mw, dec_req;
  logic [FSW-1:0] dec_fs;

  assign cls = class_e'(ir_q[OPW-1:OPW-3]);

  // State and instruction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state; IR only captures on the fetch cycle that memory completes.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_EXEC;
          ir_d    = instr;
        end
      end
      ST_EXEC: begin
        case (cls)
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_HALT:           state_d = ST_HALT;
          default:           state_d = ST_FETCH;
        endcase
      end
      ST_MEM:  if (mem_ready) state_d = ST_FETCH;
      default: state_d = ST_HALT;
    endcase
  end

  mc_insn_decode #(
    .OPW (OPW),
    .FSW (FSW)
  ) u_decode (
    .state_i     (state_q),
    .ir_i        (ir_q),
    .v_i         (V),
    .c_i         (C),
    .n_i         (N),
    .z_i         (Z),
    .mem_ready_i (mem_ready),
    .ps_o        (dec_ps),
    .il_o        (dec_il),
    .mb_o        (dec_mb),
    .fs_o        (dec_fs),
    .md_o        (dec_md),
    .rw_o        (dec_rw),
    .mm_o        (dec_mm),
    .mw_o        (dec_mw),
    .mem_req_o   (dec_req)
  );

  // Outputs are forced low while reset is held so an abandoned access never
  // leaks a strobe during the reset cycles.
  always_comb begin
    state   = reset ? 2'b00 : state_q;
    PS      = reset ? PS_HOLD : dec_ps;
    IL      = !reset && dec_il;
    MB      = !reset && dec_mb;
    FS      = reset ? '0 : dec_fs;
    MD      = !reset && dec_md;
    RW      = !reset && dec_rw;
    MM      = !reset && dec_mm;
    MW      = !reset && dec_mw;
    mem_req = !reset && dec_req;
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: instruction-level tasks drive each
// cycle and queue the control word expected from the instruction semantics;
// a negedge monitor pops and compares.
module tb_mc_control_unit;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] ps;
    logic       il;
    logic       mb;
    logic [3:0] fs;
    logic       md;
    logic       rw;
    logic       mm;
    logic       mw;
    logic       req;
  } cw_t;

  logic       clk = 1'b1;
  logic       reset;
  logic [6:0] instr;
  logic       mem_ready;
  logic       V, C, N, Z;
  logic [1:0] state;
  logic [1:0] PS;
  logic       IL, MB, MD, RW, MM, MW, mem_req;
  logic [3:0] FS;

  cw_t   exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  mc_control_unit #(.OPW(7), .FSW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .mem_ready (mem_ready),
    .V         (V),
    .C         (C),
    .N         (N),
    .Z         (Z),
    .state     (state),
    .PS        (PS),
    .IL        (IL),
    .MB        (MB),
    .FS        (FS),
    .MD        (MD),
    .RW        (RW),
    .MM        (MM),
    .MW        (MW),
    .mem_req   (mem_req)
  );

  always #5 clk = ~clk;

  function automatic cw_t zero_cw();
    cw_t e;
    e = '0;
    return e;
  endfunction

  task automatic step(input cw_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_flags();
    {V, C, N, Z} = 4'($urandom);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset     = 1'b1;
      mem_ready = 1'($urandom);
      instr     = 7'($urandom);
      rand_flags();
      step(zero_cw(), "reset");
    end
  endtask

  task automatic do_fetch(input logic [6:0] op, input int waits);
    cw_t e;
    for (int i = 0; i < waits; i++) begin
      reset = 1'b0; mem_ready = 1'b0; instr = 7'($urandom); rand_flags();
      e = zero_cw(); e.mm = 1'b1; e.req = 1'b1;
      step(e, "fetch_wait");
    end
    reset = 1'b0; mem_ready = 1'b1; instr = op; rand_flags();
    e = zero_cw(); e.mm = 1'b1; e.req = 1'b1; e.il = 1'b1; e.ps = 2'b01;
    step(e, "fetch_ready");
  endtask

  // fl = {V,C,N,Z}; condition code 0..3 picks Z,N,C,V respectively.
  task automatic do_exec(input logic [6:0] op, input logic [3:0] fl);
    cw_t        e;
    logic [2:0] cls;
    logic       picked;
    cls = op[6:4];
    reset = 1'b0; mem_ready = 1'($urandom); instr = 7'($urandom);
    {V, C, N, Z} = fl;
    picked = fl[op[1:0]];
    e = zero_cw(); e.st = 2'b01;
    case (cls)
      3'd0, 3'd1: begin e.fs = op[3:0]; e.mb = (cls == 3'd1); e.rw = 1'b1; end
      3'd4:       e.ps = picked ? 2'b10 : 2'b00;
      3'd5:       e.ps = picked ? 2'b00 : 2'b10;
      3'd6:       e.ps = 2'b11;
      default:    ;
    endcase
    step(e, (cls == 3'd4 || cls == 3'd5) ? "exec_branch" : "exec");
  endtask

  task automatic do_mem(input logic [6:0] op, input int waits, input bit complete);
    cw_t  e;
    logic is_store;
    is_store = (op[6:4] == 3'd3);
    for (int i = 0; i < waits; i++) begin
      reset = 1'b0; mem_ready = 1'b0; instr = 7'($urandom); rand_flags();
      e = zero_cw(); e.st = 2'b10; e.req = 1'b1; e.mw = is_store;
      step(e, "mem_wait");
    end
    if (complete) begin
      reset = 1'b0; mem_ready = 1'b1; instr = 7'($urandom); rand_flags();
      e = zero_cw(); e.st = 2'b10; e.req = 1'b1; e.mw = is_store;
      e.md = !is_store; e.rw = !is_store;
      step(e, "mem_ready");
    end
  endtask

  task automatic do_halt(input int n);
    cw_t e;
    for (int i = 0; i < n; i++) begin
      reset = 1'b0; mem_ready = 1'($urandom); instr = 7'($urandom); rand_flags();
      e = zero_cw(); e.st = 2'b11;
      step(e, "halt");
    end
  endtask

  task automatic run_insn(input logic [6:0] op, input int wf, input int wm);
    do_fetch(op, wf);
    do_exec(op, 4'($urandom));
    case (op[6:4])
      3'd2, 3'd3: do_mem(op, wm, 1'b1);
      3'd7: begin do_halt(10); do_reset(2); end
      default: ;
    endcase
  endtask

  // Monitor: compare the presented control word against the queued one.
  always @(negedge clk) begin
    cw_t   e, got;
    string t;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {state, PS, IL, MB, FS, MD, RW, MM, MW, mem_req};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%b ps=%b il=%b mb=%b fs=%b md=%b rw=%b mm=%b mw=%b req=%b, required st=%b ps=%b il=%b mb=%b fs=%b md=%b rw=%b mm=%b mw=%b req=%b at %0t",
                 t, got.st, got.ps, got.il, got.mb, got.fs, got.md, got.rw, got.mm, got.mw, got.req,
                 e.st, e.ps, e.il, e.mb, e.fs, e.md, e.rw, e.mm, e.mw, e.req, $time);
      end
      n_tests++;
      if ((RW && MW) || (IL && state != 2'b00)) begin
        n_fail++;
        $display("FAIL invariant: got RW=%b MW=%b IL=%b state=%b, required not(RW&MW) and IL only in state 00",
                 RW, MW, IL, state);
      end
    end
  end

  initial begin
    logic [6:0] op;
    reset = 1'b1; mem_ready = 1'b0; instr = '0; {V, C, N, Z} = 4'b0;
    do_reset(3);

    run_insn(7'b000_0101, 0, 0);
    run_insn(7'b001_1010, 1, 0);
    run_insn(7'b010_0011, 0, 2);
    run_insn(7'b011_0000, 1, 3);

    do_fetch(7'b100_0000, 0); do_exec(7'b100_0000, 4'b0001);
    do_fetch(7'b100_0000, 0); do_exec(7'b100_0000, 4'b0000);
    do_fetch(7'b101_0010, 0); do_exec(7'b101_0010, 4'b0000);
    do_fetch(7'b101_0010, 2); do_exec(7'b101_0010, 4'b0100);
    do_fetch(7'b100_0001, 0); do_exec(7'b100_0001, 4'b0010);
    do_fetch(7'b101_0011, 0); do_exec(7'b101_0011, 4'b1000);

    run_insn(7'b110_0000, 0, 0);
    run_insn(7'b111_0000, 1, 0);

    do_fetch(7'b010_0001, 0); do_exec(7'b010_0001, 4'($urandom));
    do_mem(7'b010_0001, 2, 1'b0);
    do_reset(3);
    run_insn(7'b000_0011, 0, 0);

    do_fetch(7'b011_0001, 0); do_exec(7'b011_0001, 4'($urandom));
    do_mem(7'b011_0001, 1, 1'b0);
    do_reset(1);
    run_insn(7'b011_0110, 0, 1);

    for (int k = 0; k < 200; k++) begin
      op = 7'($urandom);
      run_insn(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control sequencer for the simple datapath CPU; successor to the single-cycle opcode-to-FS decoder. It holds the instruction register and a FETCH/EXECUTE/MEMORY/HALT state machine, and drives the same datapath control word: PS, IL, MB, FS, MD, RW, MM, MW. It is parametrised in opcode and function-select width, and adds flag-conditioned branching plus a ready handshake to a variable-latency memory.

## Interface
- OPW, 7: opcode width; bits [OPW-1:OPW-3] are the class, bits [FSW-1:0] are the function/condition field; OPW ≥ FSW+3.
- FSW, 4: function-select width driven to the ALU.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  OPW  opcode from memory read data, sampled when IL=1.
- mem_ready  in  1  memory completes the current read/write this cycle.
- V, C, N, Z  in  1 each  combinational ALU flags of the current cycle.
- state  out  2  current state: 00 FETCH, 01 EXEC, 10 MEM, 11 HALT.
- PS  out  2  PC control: 00 hold, 01 increment, 10 branch (PC+offset), 11 jump (load from register A).
- IL  out  1  instruction-register load / instruction accepted.
- MB  out  1  B-operand mux: 0 register, 1 immediate.
- FS  out  FSW  ALU function select.
- MD  out  1  writeback mux: 0 ALU, 1 memory.
- RW  out  1  register-file write enable.
- MM  out  1  address mux: 1 PC, 0 register A.
- MW  out  1  memory write strobe.
- mem_req  out  1  memory access request, held until mem_ready.

## Operation
- Classes (IR top 3 bits): 000 ALU reg-reg, 001 ALU immediate, 010 load, 011 store, 100 branch-if-set, 101 branch-if-clear, 110 jump, 111 halt.
- Branch condition field IR[1:0]: 00 Z, 01 N, 10 C, 11 V.
- FETCH: MM=1, mem_req=1, PS=00 while mem_ready=0. On mem_ready=1: IL=1, PS=01, IR<=instr, next EXEC.
- EXEC, ALU classes: FS=IR[FSW-1:0], MB=class[0], MD=0, RW=1, next FETCH.
- EXEC, load/store: no strobes this cycle; next MEM.
- EXEC, branch: FS=0 (transfer A) so the flags reflect register A. PS=10 if the selected flag matches the polarity (set for 100, clear for 101), else PS=00. Next FETCH.
- EXEC, jump: PS=11, next FETCH.
- EXEC, halt: next HALT.
- MEM: MM=0, mem_req=1. Store holds MW=1 until mem_ready. Load asserts MD=1 and RW=1 only in the mem_ready cycle. Next FETCH on mem_ready, otherwise stay in MEM.
- HALT: all strobes 0, PS=00. Stays in HALT until reset.
- Any output not listed for a state is 0. FS defaults to 0.

## Timing
- Only state and IR are registered; outputs are a combinational decode of state, IR, flags and mem_ready (Mealy on mem_ready and flags).
- Reset: state<=FETCH, IR<=0. While reset=1, every output is forced to 0 (mem_req=0, PS=00, state reads 00).
- Reset asserted mid-MEM or mid-FETCH abandons the access. The first cycle after reset deassertion is FETCH with mem_req=1.
- Minimum latency per instruction: ALU/branch/jump take 2 cycles, load/store take 3, plus one extra cycle per mem_ready=0 wait cycle.
- mem_ready while mem_req=0 is ignored.
- Flags are used only in EXEC for branch classes.
- RW and MW are never both 1. IL is 1 only in FETCH.

## Structure
- Shared package ctrl_pkg holds:
  - state encoding
  - class codes
  - PS codes (PS_HOLD, PS_INC, PS_BR, PS_JMP)
  - condition-field codes
  - FS_PASS_A = 0
- One natural sub-module, mc_insn_decode: purely combinational; maps (state, IR, flags, mem_ready) to the control word. The top module keeps the state and IR registers.

## Test plan
- Reset held 3 cycles mid-MEM → all outputs 0 during reset; cycle after release shows state=00, MM=1, mem_req=1.
- ALU reg-reg, instr=7'b000_0101, mem_ready=1 → FETCH: IL=1, PS=01; EXEC: FS=0101, RW=1, MB=0, MD=0; back to FETCH on cycle 3.
- Load with mem_ready low for 2 cycles in MEM → MM=0, mem_req=1, RW=0 for 2 cycles; RW=1, MD=1 in the ready cycle; 5 cycles total.
- Store → MW=1 held across waits, RW=0 throughout, single transition to FETCH on mem_ready.
- Branch-if-set on Z (instr=100_0000): Z=1 → PS=10; Z=0 → PS=00. Branch-if-clear on C (101_0010) with C=0 → PS=10.
- Jump → PS=11 in EXEC. Halt → state=11 with all strobes 0 for 10 cycles despite mem_ready toggling; reset recovers to FETCH.
